i2c_slave_byte_ctrl: RTL and testbench
======================================

// Module: i2c_slave_byte_ctrl
// PURPOSE
//  I2C responder (slave) byte controller. Samples the raw bus lines, detects
//  START/repeated START/STOP, and shifts in the 7-bit address plus the R/W bit.
//  On an address match it ACKs, then receives bytes to the slave regs or
//  transmits bytes from them. It drives SDA open-drain via Sda_oe and does no
//  clock stretching. It is the bus-side counterpart to our master byte/bit controllers.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop depth of the SCL/SDA synchronisers (>=2)
//  NBITS        4  state register width
//  BYTE_W       8  data byte width (fixed by protocol, do not override)
// PORTS
//  Clk          in   1  system clock; single clock domain
//  Rst          in   1  reset, synchronous, active-high
//  Scl_i        in   1  raw SCL line (asynchronous)
//  Sda_i        in   1  raw SDA line (asynchronous)
//  Sda_oe       out  1  1 = pull SDA low, 0 = release
//  Slv_addr     in   7  own address, compared during the address phase
//  Rx_ack_en    in   1  1 = ACK received data bytes, 0 = NACK
//  Rx_data      out  8  last received data byte
//  Rx_valid     out  1  1-cycle pulse when Rx_data updates
//  Tx_data      in   8  next byte to transmit
//  Tx_valid     in   1  Tx_data is available
//  Tx_ready     out  1  1-cycle pulse when Tx_data is consumed
//  Tx_underrun  out  1  1-cycle pulse when 0xFF is sent because Tx_valid=0
//  Master_ack   out  1  sampled master ACK bit after a transmitted byte (0=ACK)
//  Rw           out  1  latched R/W bit of the current transfer
//  Addr_match   out  1  1-cycle pulse on address match
//  Start_det    out  1  1-cycle pulse on START or repeated START
//  Stop_det     out  1  1-cycle pulse on STOP
//  Busy         out  1  1 from START until STOP
// BEHAVIOUR
//  Reset: all outputs 0, including Sda_oe=0 (released); state=IDLE; bit counter=0.
//   Rst mid-transfer releases SDA on the next Clk edge.
//  Events come from synchronised levels. A single Clk cycle carries at most one event.
//   scl_rise: sample SDA.  scl_fall: update Sda_oe.
//   START: sda_fall while SCL=1.  STOP: sda_rise while SCL=1.
//   If SCL and SDA change in the same cycle, only the SCL edge is taken.
//  Latency: Sda_oe changes SYNC_STAGES+1 Clk cycles after the raw SCL falling edge.
//  START and STOP take priority in every state.
//   START (including repeated START): go to ADDR, clear the bit counter,
//    release SDA, pulse Start_det, set Busy=1.
//   STOP: go to IDLE, release SDA, pulse Stop_det, set Busy=0.
//  States and transitions:
//   IDLE: wait for START.
//   ADDR: shift 8 bits MSB-first on scl_rise. On the 8th scl_fall:
//    - match: latch Rw, pulse Addr_match, Sda_oe=1, go to ADDR_ACK;
//    - no match: go to WAIT_STOP.
//   ADDR_ACK: on scl_fall:
//    - Rw=0: release SDA, go to RX_BYTE;
//    - Rw=1: load the TX byte (see below), Sda_oe=~bit7, go to TX_BYTE.
//   RX_BYTE: 8 samples. On the 8th scl_fall: Rx_data<=shreg, pulse Rx_valid,
//    Sda_oe=Rx_ack_en, go to RX_ACK.
//   RX_ACK: on scl_fall, release SDA, go to RX_BYTE.
//   TX_BYTE: on each scl_fall, shift and set Sda_oe=~next bit. After bit 0's
//    scl_fall, release SDA and go to TX_ACK.
//   TX_ACK: on scl_rise, Master_ack<=Sda_i. On scl_fall:
//    - ACK: load the next byte, go to TX_BYTE;
//    - NACK: go to WAIT_STOP.
//   WAIT_STOP: SDA released; ignore bus until START or STOP.
//  TX byte load: if Tx_valid, take Tx_data and pulse Tx_ready. Otherwise send
//   0xFF and pulse Tx_underrun.
//  Width rule: bit counter is 3 bits and wraps 7->0; it is cleared on every
//   START and every state entry.
// STRUCTURE
//  i2c_slave_defines.v: state encodings, I2C_ACK=1'b0, I2C_NACK=1'b1,
//   I2C_IDLE_BYTE=8'hFF.
//  Sub-module i2c_slave_sync: SYNC_STAGES-deep synchronisers for SCL and SDA,
//   with registered outputs scl, sda, scl_rise, scl_fall, sda_rise, sda_fall.
//  Top level holds the FSM, the shift register, and the bit counter.
// TESTING
//  1 Slv_addr=0x3C; START, 0x78, 0xA5, STOP -> Addr_match pulse; Sda_oe=1 in both
//    9th clocks; Rx_data=0xA5 with a single Rx_valid; Stop_det; Busy=0.
//  2 Slv_addr=0x3C; START, 0xA4 (addr 0x52), 0x11 -> Sda_oe stays 0 throughout;
//    no Rx_valid; no Addr_match.
//  3 START, 0x79; Tx_data=0x5A then 0xC3; master ACK then NACK; STOP -> SDA shows
//    5A,C3; two Tx_ready pulses; Master_ack 0 then 1; state returns to IDLE.
//  4 Read with Tx_valid=0 -> 0xFF on SDA; Tx_underrun pulse; no Tx_ready.
//  5 Write, Rx_ack_en=0, byte 0x0F -> Rx_valid with 0x0F; Sda_oe=0 in the 9th clock.
//    Then repeated START after 4 bits of the next byte -> Start_det, no
//    Rx_valid, new address accepted.
//  6 Rst=1 during a TX bit with Sda_oe=1 -> next Clk: Sda_oe=0, Busy=0, all
//    outputs 0; next START works normally.

Source files
------------

// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// I2C responder byte controller: shared types and constants.
// State encodings, ACK/NACK levels, the idle byte and the TX byte picker.
package i2c_slave_byte_ctrl_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic       I2C_ACK       = 1'b0;
  localparam logic       I2C_NACK      = 1'b1;
  localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

  // Byte to shift out: user data if offered, else the idle pattern.
  function automatic logic [7:0] pick_tx(
    input logic       valid,
    input logic [7:0] data
  );
    return valid ? data : I2C_IDLE_BYTE;
  endfunction

endpackage

// File: rtl/i2c_slave_sync.sv
// SCL/SDA synchronisers with registered levels and edge strobes.
// The output register is the last of the SYNC_STAGES flops.
module i2c_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_rise,
  output logic sda_fall
);

  localparam int CW = SYNC_STAGES - 1;

  logic [CW-1:0] scl_sync_q, scl_sync_d;
  logic [CW-1:0] sda_sync_q, sda_sync_d;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic          scl_rise_q, scl_rise_d;
  logic          scl_fall_q, scl_fall_d;
  logic          sda_rise_q, sda_rise_d;
  logic          sda_fall_q, sda_fall_d;
  logic          scl_tap, sda_tap;

  assign scl_tap = scl_sync_q[CW-1];
  assign sda_tap = sda_sync_q[CW-1];

  // Shift the raw lines in and derive edges against the held level.
  always_comb begin
    scl_sync_d    = scl_sync_q << 1;
    scl_sync_d[0] = scl_i;
    sda_sync_d    = sda_sync_q << 1;
    sda_sync_d[0] = sda_i;
    scl_d      = scl_tap;
    sda_d      = sda_tap;
    scl_rise_d = scl_tap & ~scl_q;
    scl_fall_d = ~scl_tap & scl_q;
    sda_rise_d = sda_tap & ~sda_q;
    sda_fall_d = ~sda_tap & sda_q;
  end

  // Idle bus is high, so reset everything to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_rise_q <= 1'b0;
      sda_fall_q <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      sda_rise_q <= sda_rise_d;
      sda_fall_q <= sda_fall_d;
    end
  end

  assign scl      = scl_q;
  assign sda      = sda_q;
  assign scl_rise = scl_rise_q;
  assign scl_fall = scl_fall_q;
  assign sda_rise = sda_rise_q;
  assign sda_fall = sda_fall_q;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C responder byte controller: address match, RX and TX byte phases.
// Drives SDA open-drain through Sda_oe; no clock stretching.
module i2c_slave_byte_ctrl
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = 4,
  parameter int BYTE_W      = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Scl_i,
  input  logic              Sda_i,
  output logic              Sda_oe,
  input  logic [BYTE_W-2:0] Slv_addr,
  input  logic              Rx_ack_en,
  output logic [BYTE_W-1:0] Rx_data,
  output logic              Rx_valid,
  input  logic [BYTE_W-1:0] Tx_data,
  input  logic              Tx_valid,
  output logic              Tx_ready,
  output logic              Tx_underrun,
  output logic              Master_ack,
  output logic              Rw,
  output logic              Addr_match,
  output logic              Start_det,
  output logic              Stop_det,
  output logic              Busy
);

  logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (Clk),
    .rst     (Rst),
    .scl_i   (Scl_i),
    .sda_i   (Sda_i),
    .scl     (scl),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .sda_rise(sda_rise),
    .sda_fall(sda_fall)
  );

  // An SCL edge in the same cycle masks any SDA edge.
  assign start_ev = sda_fall & scl & ~scl_rise & ~scl_fall;
  assign stop_ev  = sda_rise & scl & ~scl_rise & ~scl_fall;

  logic [NBITS-1:0]  state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic              oe_q, oe_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_under_q, tx_under_d;
  logic              mack_q, mack_d;
  logic              rw_q, rw_d;
  logic              match_q, match_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              busy_q, busy_d;

  state_e            st, st_n;
  logic [BYTE_W-1:0] tx_byte;
  logic              rx_ack_bit;

  assign st         = state_e'(state_q);
  assign tx_byte    = pick_tx(Tx_valid, Tx_data);
  assign rx_ack_bit = Rx_ack_en ? I2C_ACK : I2C_NACK;

  // Next-state, shift/count and output pulses; START/STOP win everywhere.
  always_comb begin
    st_n       = st;
    cnt_d      = cnt_q;
    done_d     = done_q;
    sh_d       = sh_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    tx_under_d = 1'b0;
    mack_d     = mack_q;
    rw_d       = rw_q;
    match_d    = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    if (start_ev) begin
      st_n    = ST_ADDR;
      cnt_d   = '0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      start_d = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_ev) begin
      st_n   = ST_IDLE;
      oe_d   = 1'b0;
      stop_d = 1'b1;
      busy_d = 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: ;
        ST_ADDR, ST_RX_BYTE: begin
          if (scl_rise) begin
            sh_d  = {sh_q[BYTE_W-2:0], sda};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            if (st == ST_RX_BYTE) begin
              rx_data_d  = sh_q;
              rx_valid_d = 1'b1;
              oe_d       = ~rx_ack_bit;
              st_n       = ST_RX_ACK;
            end else if (sh_q[BYTE_W-1:1] == Slv_addr) begin
              rw_d    = sh_q[0];
              match_d = 1'b1;
              oe_d    = ~I2C_ACK;
              st_n    = ST_ADDR_ACK;
            end else begin
              st_n = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              sh_d       = tx_byte;
              oe_d       = ~tx_byte[BYTE_W-1];
              tx_ready_d = Tx_valid;
              tx_under_d = ~Tx_valid;
              st_n       = ST_TX_BYTE;
            end else begin
              oe_d = 1'b0;
              st_n = ST_RX_BYTE;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            oe_d = 1'b0;
            st_n = ST_RX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d = 1'b0;
              st_n = ST_TX_ACK;
            end else begin
              oe_d  = ~sh_q[BYTE_W-2];
              sh_d  = sh_q << 1;
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = sda;
          end else if (scl_fall) begin
            if (mack_q == I2C_ACK) begin
              sh_d       = tx_byte;
              oe_d       = ~tx_byte[BYTE_W-1];
              tx_ready_d = Tx_valid;
              tx_under_d = ~Tx_valid;
              st_n       = ST_TX_BYTE;
            end else begin
              st_n = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: oe_d = 1'b0;
        default:      st_n = ST_IDLE;
      endcase
    end
    if (st_n != st) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
    state_d = NBITS'(st_n);
  end

  // State and output registers; reset releases SDA on the next edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= NBITS'(ST_IDLE);
      cnt_q      <= '0;
      done_q     <= 1'b0;
      sh_q       <= '0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_under_q <= 1'b0;
      mack_q     <= 1'b0;
      rw_q       <= 1'b0;
      match_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sh_q       <= sh_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      tx_under_q <= tx_under_d;
      mack_q     <= mack_d;
      rw_q       <= rw_d;
      match_q    <= match_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign Sda_oe      = oe_q;
  assign Rx_data     = rx_data_q;
  assign Rx_valid    = rx_valid_q;
  assign Tx_ready    = tx_ready_q;
  assign Tx_underrun = tx_under_q;
  assign Master_ack  = mack_q;
  assign Rw          = rw_q;
  assign Addr_match  = match_q;
  assign Start_det   = start_q;
  assign Stop_det    = stop_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl acting as a bus master.
// RX/TX bytes are checked through expected-value queues.
module tb_i2c_slave_byte_ctrl;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [6:0] slv_addr = 7'h3C;
  logic       rx_ack_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun, master_ack, rw;
  logic       addr_match, start_det, stop_det, busy;

  int checks = 0;
  int failures = 0;
  int rxv_n = 0, am_n = 0, txr_n = 0, txu_n = 0;
  int st_n = 0, sp_n = 0, oe_n = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_byte_ctrl dut (
    .Clk        (clk),
    .Rst        (rst),
    .Scl_i      (scl_m),
    .Sda_i      (sda_bus),
    .Sda_oe     (sda_oe),
    .Slv_addr   (slv_addr),
    .Rx_ack_en  (rx_ack_en),
    .Rx_data    (rx_data),
    .Rx_valid   (rx_valid),
    .Tx_data    (tx_data),
    .Tx_valid   (tx_valid),
    .Tx_ready   (tx_ready),
    .Tx_underrun(tx_underrun),
    .Master_ack (master_ack),
    .Rw         (rw),
    .Addr_match (addr_match),
    .Start_det  (start_det),
    .Stop_det   (stop_det),
    .Busy       (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and RX scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe)      oe_n++;
      if (addr_match)  am_n++;
      if (tx_ready)    txr_n++;
      if (tx_underrun) txu_n++;
      if (start_det)   st_n++;
      if (stop_det)    sp_n++;
      if (rx_valid) begin
        rxv_n++;
        if (rx_q.size() == 0)
          chk("rx_unexpected", int'(rx_data), 'h100);
        else
          chk("rx_data", int'(rx_data), int'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic bus, output logic oe);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    bus = sda_bus;
    oe  = sda_oe;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack_oe);
    logic bus, oe;
    for (int i = 7; i >= 0; i--) bit_x(b[i], bus, oe);
    bit_x(1'b1, bus, oe);
    ack_oe = oe;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] v);
    logic bus, oe;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, bus, oe);
      v[i] = bus;
    end
    bit_x(ack, bus, oe);
  endtask

  initial begin
    logic       a;
    logic [7:0] v;
    int b_rx, b_am, b_txr, b_txu, b_st, b_sp, b_oe;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({sda_oe, rx_data, rx_valid, tx_ready, tx_underrun,
              master_ack, rw, addr_match, start_det, stop_det, busy}), 0);
    rst = 1'b0;
    wq();

    // 1: write 0xA5 to 0x3C
    b_rx = rxv_n; b_am = am_n; b_st = st_n; b_sp = sp_n;
    i2c_start();
    chk("t1_start_det", st_n - b_st, 1);
    chk("t1_busy", int'(busy), 1);
    wr_byte(8'h78, a);
    chk("t1_addr_ack_oe", int'(a), 1);
    chk("t1_addr_match", am_n - b_am, 1);
    chk("t1_rw", int'(rw), 0);
    rx_q.push_back(8'hA5);
    wr_byte(8'hA5, a);
    chk("t1_data_ack_oe", int'(a), 1);
    i2c_stop();
    wq();
    chk("t1_rx_valid_n", rxv_n - b_rx, 1);
    chk("t1_stop_det", sp_n - b_sp, 1);
    chk("t1_busy_end", int'(busy), 0);

    // 2: foreign address 0x52
    b_rx = rxv_n; b_am = am_n; b_oe = oe_n;
    i2c_start();
    wr_byte(8'hA4, a);
    chk("t2_addr_ack_oe", int'(a), 0);
    wr_byte(8'h11, a);
    i2c_stop();
    wq();
    chk("t2_oe_cycles", oe_n - b_oe, 0);
    chk("t2_rx_valid_n", rxv_n - b_rx, 0);
    chk("t2_addr_match", am_n - b_am, 0);

    // 3: read 0x5A then 0xC3, ACK then NACK
    b_txr = txr_n;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tx_q.push_back(8'h5A);
    i2c_start();
    wr_byte(8'h79, a);
    chk("t3_addr_ack_oe", int'(a), 1);
    tx_data = 8'hC3;
    tx_q.push_back(8'hC3);
    rd_byte(1'b0, v);
    chk("t3_tx0", int'(v), int'(tx_q.pop_front()));
    chk("t3_master_ack0", int'(master_ack), 0);
    rd_byte(1'b1, v);
    chk("t3_tx1", int'(v), int'(tx_q.pop_front()));
    chk("t3_master_ack1", int'(master_ack), 1);
    chk("t3_oe_after_nack", int'(sda_oe), 0);
    i2c_stop();
    wq();
    chk("t3_tx_ready_n", txr_n - b_txr, 2);
    chk("t3_busy_end", int'(busy), 0);

    // 4: read with nothing to send
    b_txr = txr_n; b_txu = txu_n;
    tx_valid = 1'b0;
    tx_q.push_back(8'hFF);
    i2c_start();
    wr_byte(8'h79, a);
    rd_byte(1'b1, v);
    chk("t4_tx_idle", int'(v), int'(tx_q.pop_front()));
    i2c_stop();
    wq();
    chk("t4_underrun_n", txu_n - b_txu, 1);
    chk("t4_tx_ready_n", txr_n - b_txr, 0);

    // 5: NACKed write, then repeated START mid-byte
    b_rx = rxv_n; b_st = st_n; b_am = am_n;
    rx_ack_en = 1'b0;
    i2c_start();
    wr_byte(8'h78, a);
    chk("t5_addr_ack_oe", int'(a), 1);
    rx_q.push_back(8'h0F);
    wr_byte(8'h0F, a);
    chk("t5_data_nack_oe", int'(a), 0);
    chk("t5_rx_valid_n", rxv_n - b_rx, 1);
    begin
      logic bus, oe;
      bit_x(1'b1, bus, oe);
      bit_x(1'b0, bus, oe);
      bit_x(1'b1, bus, oe);
      bit_x(1'b0, bus, oe);
    end
    i2c_start();
    chk("t5_rstart_det", st_n - b_st, 2);
    chk("t5_busy", int'(busy), 1);
    wr_byte(8'h79, a);
    chk("t5_new_addr_ack", int'(a), 1);
    chk("t5_addr_match_n", am_n - b_am, 2);
    chk("t5_rw", int'(rw), 1);
    chk("t5_rx_no_extra", rxv_n - b_rx, 1);
    i2c_stop();
    wq();
    rx_ack_en = 1'b1;

    // 6: reset while driving a zero TX bit
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    i2c_start();
    wr_byte(8'h79, a);
    scl_m = 1'b1;
    wq();
    chk("t6_oe_before_rst", int'(sda_oe), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_reset_outputs",
        int'({sda_oe, rx_data, rx_valid, tx_ready, tx_underrun,
              master_ack, rw, addr_match, start_det, stop_det, busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    scl_m = 1'b0;
    wq();
    b_st = st_n; b_am = am_n;
    i2c_start();
    chk("t6_start_after_rst", st_n - b_st, 1);
    wr_byte(8'h78, a);
    chk("t6_addr_ack_oe", int'(a), 1);
    chk("t6_addr_match", am_n - b_am, 1);
    i2c_stop();
    wq();
    chk("t6_busy_end", int'(busy), 0);
    chk("rx_queue_drained", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
